// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler
// Shares one single-port monochrome framebuffer between display prefetch and
// a host write port. A small word FIFO runs ahead of the raster. Words are
// shifted out MSB-first as pixels, and an empty FIFO at pop time raises a
// sticky underrun flag.
//
// Host handshake: host_valid/host_ready use strict valid/ready semantics.
// A write is accepted, and issued to memory in the same cycle, exactly when
// host_valid && host_ready. host_ready never depends on host_valid, and it is
// held low while reset is asserted.
module vga_fb_scheduler #(
  parameter int H_DISPLAY  = 1024,
  parameter int V_DISPLAY  = 768,
  parameter int WORD_W     = 8,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4,
  parameter int LOW_WATER  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hpos,
  input  logic [9:0]        vpos,
  input  logic              display_on,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WORD_W-1:0] host_wdata,
  output logic              pixel,
  output logic              frame_start,
  output logic              underrun
);

  localparam int TOTAL_WORDS = H_DISPLAY * V_DISPLAY / WORD_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [ADDR_W:0] END_ADDR = (ADDR_W+1)'(TOTAL_WORDS);
  localparam logic [CW:0]     DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW:0]     LOW_C    = (CW+1)'(LOW_WATER);
  localparam logic [9:0]      V_END    = 10'(V_DISPLAY);
  localparam logic [PW-1:0]   PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WORD_W - 1);

  // Prefetch FIFO state
  logic [WORD_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Fetch state
  // fetch_addr is one bit wider than ADDR_W so it can hold the end-of-frame value.
  logic [ADDR_W:0]   fetch_addr_q, fetch_addr_d;
  logic              inflight_q, inflight_d;
  logic              armed_q, armed_d;

  // Serialiser state
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              pixel_q, pixel_d;
  logic              underrun_q, underrun_d;
  logic              frame_start_q;

  // Last driven memory address/data, so an idle cycle holds them.
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;

  logic [CW:0]       occ;
  logic              restart, disp_req, urgent, wr_grant, rd_grant;
  logic              push, pop, do_pop, fifo_empty;
  logic [WORD_W-1:0] pop_word;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Arbitration: the restart cycle blocks everything, urgent display reads
  // pre-empt the host, otherwise the host wins and reads fill idle slots.
  always_comb begin
    restart    = (vpos == V_END) && (hpos == '0);
    occ        = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    disp_req   = armed_q && (fetch_addr_q < END_ADDR) && (occ < DEPTH_C);
    urgent     = disp_req && (occ < LOW_C);
    host_ready = reset && !urgent && !restart;
    wr_grant   = host_valid && host_ready;
    rd_grant   = !wr_grant && disp_req && !restart;
    mem_wr     = wr_grant;
    mem_rd     = rd_grant;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    if (wr_grant) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (rd_grant) begin
      mem_addr  = fetch_addr_q[ADDR_W-1:0];
    end
  end

  // FIFO pointer and occupancy next-state; a restart flushes everything,
  // including the word returning this cycle.
  always_comb begin
    fifo_empty = (count_q == '0);
    push       = inflight_q && !restart;
    pop        = display_on && (bitcnt_q == '0);
    do_pop     = pop && !fifo_empty;
    pop_word   = fifo_empty ? '0 : fifo_q[rd_ptr_q];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (restart) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !do_pop)      count_d = count_q + 1'b1;
      else if (!push && do_pop) count_d = count_q - 1'b1;
    end
  end

  // Fetch address, outstanding-read flag and arming next-state.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    inflight_d   = rd_grant;
    armed_d      = armed_q;
    if (restart) begin
      fetch_addr_d = '0;
      inflight_d   = 1'b0;
      armed_d      = 1'b1;
    end else if (rd_grant) begin
      fetch_addr_d = fetch_addr_q + 1'b1;
    end
  end

  // Serialiser next-state: pop a word on the first pixel of each group,
  // otherwise shift. An empty pop yields zeros and flags an underrun once armed.
  always_comb begin
    pixel_d    = 1'b0;
    shreg_d    = shreg_q;
    bitcnt_d   = '0;
    underrun_d = underrun_q;
    if (display_on) begin
      bitcnt_d = (bitcnt_q == BIT_LAST) ? '0 : bitcnt_q + 1'b1;
      if (bitcnt_q == '0) begin
        pixel_d = pop_word[WORD_W-1];
        shreg_d = pop_word << 1;
        if (fifo_empty && armed_q) underrun_d = 1'b1;
      end else begin
        pixel_d = shreg_q[WORD_W-1];
        shreg_d = shreg_q << 1;
      end
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= mem_rdata;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Fetch state and the held memory address/data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
      armed_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= inflight_d;
      armed_q      <= armed_d;
      addr_q       <= mem_addr;
      wdata_q      <= mem_wdata;
    end
  end

  // Serialiser, underrun flag and frame-start pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt_q      <= '0;
      shreg_q       <= '0;
      pixel_q       <= 1'b0;
      underrun_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      bitcnt_q      <= bitcnt_d;
      shreg_q       <= shreg_d;
      pixel_q       <= pixel_d;
      underrun_q    <= underrun_d;
      frame_start_q <= restart;
    end
  end

  assign pixel       = pixel_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
